nios_sys_pio_in_edge: RTL and testbench

- Parametrised successor to the fixed 4-bit input PIO on the NIOS_Sys Avalon-MM bus.
- Samples a WIDTH-bit input port through a synchroniser and returns the value on a registered read.
- Adds per-bit edge capture, a write-1-to-clear capture register and a maskable level interrupt to the Nios II CPU, for LegoCar sensors and buttons.

---
 rtl/nios_sys_pio_in_edge.sv | 113 +++++++++++
 tb/tb_nios_sys_pio_in_edge.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/nios_sys_pio_in_edge.sv
// Avalon-MM input PIO: synchronised WIDTH-bit input, per-bit edge capture with
// write-1-to-clear, maskable level interrupt and a registered read port.
module nios_sys_pio_in_edge #(
   parameter int unsigned WIDTH       = 4,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned EDGE_TYPE   = 0,
   parameter int unsigned IRQ_EN      = 1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [1:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   input  logic [WIDTH-1:0] in_port,
   output logic [31:0]      readdata,
   output logic             irq
);

   localparam logic [1:0] AddrData = 2'd0;
   localparam logic [1:0] AddrMask = 2'd2;
   localparam logic [1:0] AddrCap  = 2'd3;

   logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
   logic [WIDTH-1:0]                  prev_q, prev_d;
   logic [WIDTH-1:0]                  irqmask_q, irqmask_d;
   logic [WIDTH-1:0]                  edgecap_q, edgecap_d;
   logic [31:0]                       readdata_q, readdata_d;

   logic [WIDTH-1:0] synced;
   logic [WIDTH-1:0] edge_det;
   logic [WIDTH-1:0] cap_clr;
   logic             wr_en;

   assign synced = sync_q[SYNC_STAGES-1];
   assign wr_en  = chipselect & ~write_n;

   always_comb begin
      sync_d    = sync_q;
      sync_d[0] = in_port;
      for (int k = 1; k < SYNC_STAGES; k++) begin
         sync_d[k] = sync_q[k-1];
      end
      prev_d = synced;
   end

   always_comb begin
      edge_det = '0;
      if (EDGE_TYPE == 0) begin
         edge_det = synced & ~prev_q;
      end else if (EDGE_TYPE == 1) begin
         edge_det = ~synced & prev_q;
      end else begin
         edge_det = synced ^ prev_q;
      end
   end

   // A new edge in the same cycle as a W1C write wins, so no event is lost.
   always_comb begin
      cap_clr = '0;
      if (wr_en && address == AddrCap) begin
         cap_clr = writedata[WIDTH-1:0];
      end
      edgecap_d = edge_det | (edgecap_q & ~cap_clr);
   end

   always_comb begin
      irqmask_d = irqmask_q;
      if (IRQ_EN == 0) begin
         irqmask_d = '0;
      end else if (wr_en && address == AddrMask) begin
         irqmask_d = writedata[WIDTH-1:0];
      end
   end

   // Read mux is sampled every clock regardless of chipselect.
   always_comb begin
      readdata_d = '0;
      case (address)
         AddrData: readdata_d[WIDTH-1:0] = synced;
         AddrMask: readdata_d[WIDTH-1:0] = irqmask_q;
         AddrCap:  readdata_d[WIDTH-1:0] = edgecap_q;
         default:  readdata_d = '0;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_q     <= '0;
         prev_q     <= '0;
         irqmask_q  <= '0;
         edgecap_q  <= '0;
         readdata_q <= '0;
      end else begin
         sync_q     <= sync_d;
         prev_q     <= prev_d;
         irqmask_q  <= irqmask_d;
         edgecap_q  <= edgecap_d;
         readdata_q <= readdata_d;
      end
   end

   assign readdata = readdata_q;
   assign irq      = (IRQ_EN != 0) && (|(edgecap_q & irqmask_q));

   generate
      if (WIDTH < 32) begin : g_unused_wdata
         logic unused_wdata;
         assign unused_wdata = ^writedata[31:WIDTH];
      end
   endgenerate

endmodule

// File: tb/tb_nios_sys_pio_in_edge.sv
// Directed and random checks of the input PIO across edge modes, a 32-bit
// build with irq disabled, and asynchronous reset, against a delay-line model.
module tb_nios_sys_pio_in_edge;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [1:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [3:0]  in4;
   logic [31:0] in32;
   logic [31:0] rd [4];
   logic        irq_o [4];

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   nios_sys_pio_in_edge #(.WIDTH(4), .SYNC_STAGES(2), .EDGE_TYPE(0), .IRQ_EN(1)) dut0 (
      .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .in_port(in4), .readdata(rd[0]), .irq(irq_o[0]));
   nios_sys_pio_in_edge #(.WIDTH(4), .SYNC_STAGES(2), .EDGE_TYPE(1), .IRQ_EN(1)) dut1 (
      .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .in_port(in4), .readdata(rd[1]), .irq(irq_o[1]));
   nios_sys_pio_in_edge #(.WIDTH(4), .SYNC_STAGES(2), .EDGE_TYPE(2), .IRQ_EN(1)) dut2 (
      .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .in_port(in4), .readdata(rd[2]), .irq(irq_o[2]));
   nios_sys_pio_in_edge #(.WIDTH(32), .SYNC_STAGES(3), .EDGE_TYPE(2), .IRQ_EN(0)) dut3 (
      .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .in_port(in32), .readdata(rd[3]), .irq(irq_o[3]));

   // Reference model: the input seen by the logic is the pin value delayed by
   // the synchroniser depth; the previous value is one sample older still.
   logic [31:0] hist [4][5];
   logic [31:0] m_mask [4];
   logic [31:0] m_cap [4];
   logic [31:0] m_rd [4];

   function automatic int unsigned stg(int i);
      return (i == 3) ? 3 : 2;
   endfunction
   function automatic int unsigned etype(int i);
      return (i == 3) ? 2 : i;
   endfunction
   function automatic logic [31:0] wmask(int i);
      return (i == 3) ? 32'hFFFF_FFFF : 32'h0000_000F;
   endfunction
   function automatic bit irq_en(int i);
      return i != 3;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 4; i++) begin
         for (int k = 0; k < 5; k++) hist[i][k] = '0;
         m_mask[i] = '0;
         m_cap[i]  = '0;
         m_rd[i]   = '0;
      end
   endtask

   task automatic model_clock();
      logic [31:0] s, p, e, pin;
      bit wr;
      wr = chipselect && !write_n;
      for (int i = 0; i < 4; i++) begin
         s = hist[i][stg(i)-1];
         p = hist[i][stg(i)];
         case (etype(i))
            0:       e = s & ~p;
            1:       e = ~s & p;
            default: e = s ^ p;
         endcase
         e &= wmask(i);
         case (address)
            2'd0:    m_rd[i] = s;
            2'd2:    m_rd[i] = m_mask[i];
            2'd3:    m_rd[i] = m_cap[i];
            default: m_rd[i] = 32'h0;
         endcase
         if (wr && address == 2'd3) m_cap[i] = e | (m_cap[i] & ~writedata & wmask(i));
         else m_cap[i] = e | m_cap[i];
         if (!irq_en(i)) m_mask[i] = '0;
         else if (wr && address == 2'd2) m_mask[i] = writedata & wmask(i);
         pin = (i == 3) ? in32 : {28'h0, in4};
         for (int k = 4; k > 0; k--) hist[i][k] = hist[i][k-1];
         hist[i][0] = pin & wmask(i);
      end
   endtask

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      logic [31:0] exp_irq;
      for (int i = 0; i < 4; i++) begin
         exp_irq = {31'h0, irq_en(i) && (|(m_cap[i] & m_mask[i]))};
         chk($sformatf("readdata_dut%0d", i), rd[i], m_rd[i]);
         chk($sformatf("irq_dut%0d", i), {31'h0, irq_o[i]}, exp_irq);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      if (!reset_n) model_reset();
      else model_clock();
      #1;
      check_all();
   endtask

   task automatic bus_wr(logic [1:0] a, logic [31:0] d);
      address    = a;
      chipselect = 1'b1;
      write_n    = 1'b0;
      writedata  = d;
      tick();
      chipselect = 1'b0;
      write_n    = 1'b1;
   endtask

   task automatic rand_phase(int n);
      for (int j = 0; j < n; j++) begin
         in4        = 4'($urandom);
         in32       = $urandom;
         address    = 2'($urandom);
         chipselect = ($urandom_range(0, 3) == 0);
         write_n    = ($urandom_range(0, 1) == 0);
         writedata  = $urandom;
         tick();
      end
      chipselect = 1'b0;
      write_n    = 1'b1;
   endtask

   initial begin
      address = 2'd0; chipselect = 1'b0; write_n = 1'b1; writedata = '0;
      in4 = '0; in32 = '0;
      model_reset();
      #12;
      check_all();

      // Static input readback
      in4 = 4'b1010; in32 = 32'hA5A5_1234;
      reset_n = 1'b1;
      repeat (5) tick();
      chk("data_read", rd[0], 32'h0000_000A);
      chk("data_read_w32", rd[3], 32'hA5A5_1234);
      address = 2'd1;
      tick();
      chk("reserved_read", rd[0], 32'h0);
      chk("irq_mask0", {31'h0, irq_o[0]}, 32'h0);

      // Rising capture on bit2, irq, then W1C
      bus_wr(2'd2, 32'hF);
      in4 = 4'b0000;
      repeat (4) tick();
      bus_wr(2'd3, 32'hFFFF_FFFF);
      address = 2'd3;
      in4 = 4'b0100;
      repeat (3) tick();
      chk("irq_rise", {31'h0, irq_o[0]}, 32'h1);
      tick();
      chk("cap_bit2", rd[0], 32'h4);
      bus_wr(2'd3, 32'h4);
      chk("irq_cleared", {31'h0, irq_o[0]}, 32'h0);
      address = 2'd3;
      tick();
      chk("cap_cleared", rd[0], 32'h0);

      // Mask gating
      bus_wr(2'd2, 32'h1);
      address = 2'd3;
      in4 = 4'b1100;
      repeat (4) tick();
      chk("cap_bit3", rd[0], 32'h8);
      chk("irq_masked", {31'h0, irq_o[0]}, 32'h0);
      bus_wr(2'd2, 32'h9);
      chk("irq_unmasked", {31'h0, irq_o[0]}, 32'h1);

      // Set and W1C clear in the same cycle: set wins
      bus_wr(2'd3, 32'hF);
      in4 = 4'b1101;
      repeat (2) tick();
      bus_wr(2'd3, 32'h1);
      address = 2'd3;
      tick();
      chk("set_wins", rd[0], 32'h1);

      // Falling-only vs any-edge on bit1
      bus_wr(2'd3, 32'hFFFF_FFFF);
      in4 = 4'b1111;
      address = 2'd3;
      repeat (5) tick();
      chk("fall_ignores_rise", rd[1] & 32'h2, 32'h0);
      chk("any_sees_rise", rd[2] & 32'h2, 32'h2);
      bus_wr(2'd3, 32'h2);
      address = 2'd3;
      in4 = 4'b1101;
      repeat (5) tick();
      chk("fall_sees_fall", rd[1] & 32'h2, 32'h2);
      chk("any_sees_fall", rd[2] & 32'h2, 32'h2);

      rand_phase(400);

      // Asynchronous reset with captures pending and irq high
      bus_wr(2'd2, 32'hF);
      in4 = 4'b0000;
      repeat (4) tick();
      bus_wr(2'd3, 32'hFFFF_FFFF);
      in4 = 4'b1111;
      address = 2'd3;
      repeat (5) tick();
      chk("pre_reset_cap", rd[0], 32'hF);
      chk("pre_reset_irq", {31'h0, irq_o[0]}, 32'h1);
      #3;
      reset_n = 1'b0;
      model_reset();
      #1;
      check_all();
      chk("reset_irq", {31'h0, irq_o[0]}, 32'h0);
      chk("reset_rd", rd[0], 32'h0);
      address = 2'd2;
      tick();
      chk("reset_mask", rd[0], 32'h0);
      #2;
      reset_n = 1'b1;
      rand_phase(200);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
